// File: rtl/lipsi_pkg.sv
// Shared constants for the Lipsi run controller: controller state codes,
// host command opcodes and a small state-decode helper.
package lipsi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_HALTED = 3'd3,
        ST_CRST   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_LOAD_ADDR = 3'd1,
        OP_LOAD_BYTE = 3'd2,
        OP_RUN       = 3'd3,
        OP_STEP      = 3'd4,
        OP_HALT      = 3'd5,
        OP_SET_BP    = 3'd6,
        OP_CPU_RESET = 3'd7
    } cmd_op_t;

    localparam logic [7:0] PTR_RESET = 8'h00;
    localparam logic [7:0] BP_RESET  = 8'h00;

    // The host may only issue commands while the controller is not in the
    // middle of a single step or a processor reset pulse.
    function automatic logic isReadyState(input state_t s);
        return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_HALTED);
    endfunction

endpackage

// File: rtl/lipsi_sat_cnt.sv
// Saturating up-counter used to count executed processor cycles.
// A clear request takes precedence over an increment in the same cycle.
module lipsi_sat_cnt
    import lipsi_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count up on every enabled edge, holding at all-ones once reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/lipsi_run_ctrl.sv
// Host-side run controller for the Lipsi processor: loads instruction
// memory, starts/steps/halts the core, handles a single breakpoint and
// generates a timed processor reset pulse.
module lipsi_run_ctrl
    import lipsi_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int CYC_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_data,
    input  logic [7:0]       cpu_pc,
    input  logic             cpu_exit,
    output logic             cpu_en,
    output logic             cpu_rst,
    output logic             imem_we,
    output logic [7:0]       imem_addr,
    output logic [7:0]       imem_wdata,
    output logic [2:0]       state,
    output logic             bp_hit,
    output logic [CYC_W-1:0] cycles
);

    // The reset-pulse counter counts down from RST_CYCLES-1 to zero, so the
    // controller sits in CRST for exactly RST_CYCLES cycles.
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LOAD = RCW'(RST_CYCLES - 1);

    state_t         r_state;
    logic [7:0]     r_loadPtr;
    logic [7:0]     r_bpAddr;
    logic           r_bpEn;
    logic           r_bpHit;
    logic           r_firstRun;
    logic           r_imemWe;
    logic [7:0]     r_imemAddr;
    logic [7:0]     r_imemWdata;
    logic [RCW-1:0] r_rstCnt;

    logic w_accept;
    logic w_cpuReset;
    logic w_halt;
    logic w_bpMatch;

    assign cmd_ready  = isReadyState(r_state);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_cpuReset = w_accept && (cmd_op == OP_CPU_RESET);
    assign w_halt     = w_accept && (cmd_op == OP_HALT);
    assign w_bpMatch  = r_bpEn && !r_firstRun && (cpu_pc == r_bpAddr);

    // Main controller FSM together with the load pointer, breakpoint
    // registers and the one-cycle instruction-memory write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_loadPtr   <= PTR_RESET;
            r_bpAddr    <= BP_RESET;
            r_bpEn      <= 1'b0;
            r_bpHit     <= 1'b0;
            r_firstRun  <= 1'b0;
            r_imemWe    <= 1'b0;
            r_imemAddr  <= 8'h00;
            r_imemWdata <= 8'h00;
            r_rstCnt    <= '0;
        end else begin
            r_imemWe <= 1'b0;
            if (w_cpuReset) begin
                r_state  <= ST_CRST;
                r_rstCnt <= RST_LOAD;
                r_bpEn   <= 1'b0;
                r_bpHit  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_HALTED: begin
                        if (w_accept) begin
                            case (cmd_op_t'(cmd_op))
                                OP_LOAD_ADDR: r_loadPtr <= cmd_data;
                                OP_LOAD_BYTE: begin
                                    r_imemWe    <= 1'b1;
                                    r_imemAddr  <= r_loadPtr;
                                    r_imemWdata <= cmd_data;
                                    r_loadPtr   <= r_loadPtr + 8'd1;
                                end
                                OP_RUN: begin
                                    r_state    <= ST_RUN;
                                    r_bpHit    <= 1'b0;
                                    r_firstRun <= 1'b1;
                                end
                                OP_STEP:      r_state <= ST_STEP;
                                OP_SET_BP: begin
                                    r_bpAddr <= cmd_data;
                                    r_bpEn   <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_RUN: begin
                        r_firstRun <= 1'b0;
                        if (w_halt) begin
                            r_state <= ST_HALTED;
                        end else if (cpu_exit) begin
                            r_state <= ST_HALTED;
                        end else if (w_bpMatch) begin
                            r_state <= ST_HALTED;
                            r_bpHit <= 1'b1;
                        end
                    end
                    ST_STEP: begin
                        r_state <= ST_HALTED;
                    end
                    ST_CRST: begin
                        if (r_rstCnt == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_rstCnt <= r_rstCnt - 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign cpu_en     = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign cpu_rst    = reset || (r_state == ST_CRST);
    assign imem_we    = r_imemWe;
    assign imem_addr  = r_imemAddr;
    assign imem_wdata = r_imemWdata;
    assign state      = r_state;
    assign bp_hit     = r_bpHit;

    lipsi_sat_cnt #(
        .W(CYC_W)
    ) u_cycCnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_cpuReset),
        .i_inc (cpu_en),
        .o_cnt (cycles)
    );

endmodule

// File: tb/tb_lipsi_run_ctrl.sv
// Self-checking bench for lipsi_run_ctrl: a vector table for the command
// level behaviour, hand-written sequences for multi-cycle corner cases and
// a scoreboard for instruction-memory writes.
module tb_lipsi_run_ctrl;
    import lipsi_pkg::*;

    localparam int CYC_W = 4;
    localparam int NVEC  = 26;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [7:0]       cmd_data;
    logic [7:0]       cpu_pc;
    logic             cpu_exit;
    logic             cpu_en;
    logic             cpu_rst;
    logic             imem_we;
    logic [7:0]       imem_addr;
    logic [7:0]       imem_wdata;
    logic [2:0]       state;
    logic             bp_hit;
    logic [CYC_W-1:0] cycles;

    lipsi_run_ctrl #(
        .RST_CYCLES(2),
        .CYC_W     (CYC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cpu_pc    (cpu_pc),
        .cpu_exit  (cpu_exit),
        .cpu_en    (cpu_en),
        .cpu_rst   (cpu_rst),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .state     (state),
        .bp_hit    (bp_hit),
        .cycles    (cycles)
    );

    typedef struct {
        logic             valid;
        logic [2:0]       op;
        logic [7:0]       data;
        logic [7:0]       pc;
        logic             ex;
        logic             eff;
        logic [2:0]       eState;
        logic             eReady;
        logic             eEn;
        logic             eRst;
        logic             eBp;
        logic [CYC_W-1:0] eCyc;
    } vec_t;

    vec_t        vecs[NVEC];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] wrQueue[$];
    logic [15:0] expWr;
    logic [7:0]  modelPtr;
    logic [CYC_W-1:0] expCyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkStatus(input string name, input logic [2:0] eState, input logic eReady,
                               input logic eEn, input logic eRst, input logic eBp,
                               input logic [CYC_W-1:0] eCyc);
        checkOutput({name, ".state"},  32'(state),     32'(eState));
        checkOutput({name, ".ready"},  32'(cmd_ready), 32'(eReady));
        checkOutput({name, ".cpuEn"},  32'(cpu_en),    32'(eEn));
        checkOutput({name, ".cpuRst"}, 32'(cpu_rst),   32'(eRst));
        checkOutput({name, ".bpHit"},  32'(bp_hit),    32'(eBp));
        checkOutput({name, ".cycles"}, 32'(cycles),    32'(eCyc));
    endtask

    // Drive one cycle of inputs; effective loads update the bench pointer
    // model and push the expected memory write onto the scoreboard.
    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [7:0] d,
                                 input logic [7:0] pc, input logic ex, input logic eff);
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        cpu_pc    = pc;
        cpu_exit  = ex;
        if (eff && (op == OP_LOAD_ADDR)) modelPtr = d;
        if (eff && (op == OP_LOAD_BYTE)) begin
            wrQueue.push_back({modelPtr, d});
            modelPtr = modelPtr + 8'd1;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cpu_exit  = 1'b0;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [7:0] d, input logic [7:0] pc, input logic ex);
        applyStimulus(1'b1, op, d, pc, ex, 1'b1);
    endtask

    task automatic idle(input logic [7:0] pc, input logic ex);
        applyStimulus(1'b0, OP_NOP, 8'h00, pc, ex, 1'b0);
    endtask

    // Scoreboard side: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            if (wrQueue.size() == 0) begin
                checkOutput("imemUnexpectedWrite", 32'(imem_we), 32'd0);
            end else begin
                expWr = wrQueue.pop_front();
                checkOutput("imemAddr",  32'(imem_addr),  32'(expWr[15:8]));
                checkOutput("imemWdata", 32'(imem_wdata), 32'(expWr[7:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //         valid  op            data   pc     ex    eff   eState     rdy   en    rst   bp    cyc
        vecs[0]  = '{1'b1, OP_LOAD_ADDR, 8'hFE, 8'h00, 1'b0, 1'b1, ST_IDLE,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, OP_LOAD_BYTE, 8'hC7, 8'h00, 1'b0, 1'b1, ST_IDLE,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, OP_LOAD_BYTE, 8'h0A, 8'h00, 1'b0, 1'b1, ST_IDLE,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, OP_LOAD_BYTE, 8'h81, 8'h00, 1'b0, 1'b1, ST_IDLE,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[4]  = '{1'b1, OP_NOP,       8'h00, 8'h00, 1'b0, 1'b0, ST_IDLE,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[5]  = '{1'b1, OP_HALT,      8'h00, 8'h00, 1'b0, 1'b0, ST_IDLE,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[6]  = '{1'b1, OP_SET_BP,    8'h04, 8'h00, 1'b0, 1'b0, ST_IDLE,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[7]  = '{1'b1, OP_STEP,      8'h00, 8'h00, 1'b0, 1'b0, ST_STEP,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[8]  = '{1'b1, OP_LOAD_BYTE, 8'h55, 8'h00, 1'b0, 1'b0, ST_HALTED, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[9]  = '{1'b1, OP_RUN,       8'h00, 8'h00, 1'b0, 1'b0, ST_RUN,    1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[10] = '{1'b1, OP_LOAD_BYTE, 8'h33, 8'h01, 1'b0, 1'b0, ST_RUN,    1'b1, 1'b1, 1'b0, 1'b0, 4'd2};
        vecs[11] = '{1'b1, OP_SET_BP,    8'h09, 8'h02, 1'b0, 1'b0, ST_RUN,    1'b1, 1'b1, 1'b0, 1'b0, 4'd3};
        vecs[12] = '{1'b0, OP_NOP,       8'h00, 8'h04, 1'b0, 1'b0, ST_HALTED, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4};
        vecs[13] = '{1'b0, OP_NOP,       8'h00, 8'h04, 1'b0, 1'b0, ST_HALTED, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4};
        vecs[14] = '{1'b1, OP_RUN,       8'h00, 8'h04, 1'b0, 1'b0, ST_RUN,    1'b1, 1'b1, 1'b0, 1'b0, 4'd4};
        vecs[15] = '{1'b0, OP_NOP,       8'h00, 8'h04, 1'b0, 1'b0, ST_RUN,    1'b1, 1'b1, 1'b0, 1'b0, 4'd5};
        vecs[16] = '{1'b0, OP_NOP,       8'h00, 8'h05, 1'b0, 1'b0, ST_RUN,    1'b1, 1'b1, 1'b0, 1'b0, 4'd6};
        vecs[17] = '{1'b0, OP_NOP,       8'h00, 8'h04, 1'b0, 1'b0, ST_HALTED, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7};
        vecs[18] = '{1'b1, OP_HALT,      8'h00, 8'h04, 1'b0, 1'b0, ST_HALTED, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7};
        vecs[19] = '{1'b1, OP_CPU_RESET, 8'h00, 8'h04, 1'b0, 1'b0, ST_CRST,   1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[20] = '{1'b0, OP_NOP,       8'h00, 8'h04, 1'b0, 1'b0, ST_CRST,   1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[21] = '{1'b0, OP_NOP,       8'h00, 8'h04, 1'b0, 1'b0, ST_IDLE,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[22] = '{1'b1, OP_RUN,       8'h00, 8'h04, 1'b0, 1'b0, ST_RUN,    1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[23] = '{1'b0, OP_NOP,       8'h00, 8'h05, 1'b0, 1'b0, ST_RUN,    1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[24] = '{1'b0, OP_NOP,       8'h00, 8'h04, 1'b0, 1'b0, ST_RUN,    1'b1, 1'b1, 1'b0, 1'b0, 4'd2};
        vecs[25] = '{1'b1, OP_HALT,      8'h00, 8'h04, 1'b0, 1'b0, ST_HALTED, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3};

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = 8'h00;
        cpu_pc    = 8'h00;
        cpu_exit  = 1'b0;
        modelPtr  = 8'h00;

        #2;
        reset = 1'b1;
        #1;
        $display("[TB] checking reset state");
        checkStatus("reset", ST_IDLE, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("reset.imemWe", 32'(imem_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("resetRelease.cpuRst", 32'(cpu_rst), 32'd0);

        $display("[TB] applying vector table");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].op, vecs[i].data, vecs[i].pc, vecs[i].ex, vecs[i].eff);
            checkStatus($sformatf("vec%0d", i), vecs[i].eState, vecs[i].eReady, vecs[i].eEn,
                        vecs[i].eRst, vecs[i].eBp, vecs[i].eCyc);
            checkOutput($sformatf("vec%0d.imemWe", i), 32'(imem_we),
                        32'(vecs[i].eff && (vecs[i].op == OP_LOAD_BYTE)));
        end

        $display("[TB] run until cpu_exit after ten cycles");
        cmd(OP_CPU_RESET, 8'h00, 8'h00, 1'b0);
        checkStatus("seqA.crst", ST_CRST, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        idle(8'h00, 1'b0);
        idle(8'h00, 1'b0);
        checkStatus("seqA.idle", ST_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cmd(OP_RUN, 8'h00, 8'h00, 1'b0);
        checkStatus("seqA.run", ST_RUN, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 9; i++) begin
            idle(8'(i + 1), 1'b0);
            checkStatus($sformatf("seqA.cyc%0d", i), ST_RUN, 1'b1, 1'b1, 1'b0, 1'b0, 4'(i + 1));
        end
        idle(8'h0A, 1'b1);
        checkStatus("seqA.exit", ST_HALTED, 1'b1, 1'b0, 1'b0, 1'b0, 4'd10);

        $display("[TB] three single steps");
        for (int k = 0; k < 3; k++) begin
            cmd(OP_STEP, 8'h00, 8'h0A, 1'b0);
            checkStatus($sformatf("seqB.step%0d", k), ST_STEP, 1'b0, 1'b1, 1'b0, 1'b0, 4'(10 + k));
            idle(8'h0A, 1'b0);
            checkStatus($sformatf("seqB.halt%0d", k), ST_HALTED, 1'b1, 1'b0, 1'b0, 1'b0, 4'(11 + k));
        end

        $display("[TB] halt with exit, then processor reset and priorities");
        cmd(OP_RUN, 8'h00, 8'h0A, 1'b0);
        checkStatus("seqC.run", ST_RUN, 1'b1, 1'b1, 1'b0, 1'b0, 4'd13);
        cmd(OP_HALT, 8'h00, 8'h0A, 1'b1);
        checkStatus("seqC.haltExit", ST_HALTED, 1'b1, 1'b0, 1'b0, 1'b0, 4'd14);
        cmd(OP_CPU_RESET, 8'h00, 8'h0A, 1'b0);
        checkStatus("seqC.crst1", ST_CRST, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        idle(8'h0A, 1'b0);
        checkStatus("seqC.crst2", ST_CRST, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        idle(8'h0A, 1'b0);
        checkStatus("seqC.idle", ST_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cmd(OP_SET_BP, 8'h20, 8'h00, 1'b0);
        cmd(OP_RUN, 8'h00, 8'h00, 1'b0);
        idle(8'h01, 1'b0);
        checkStatus("seqC.run2", ST_RUN, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        cmd(OP_CPU_RESET, 8'h00, 8'h20, 1'b1);
        checkStatus("seqC.rstWins", ST_CRST, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        idle(8'h00, 1'b0);
        idle(8'h00, 1'b0);
        cmd(OP_SET_BP, 8'h20, 8'h00, 1'b0);
        cmd(OP_RUN, 8'h00, 8'h00, 1'b0);
        idle(8'h01, 1'b0);
        idle(8'h20, 1'b1);
        checkStatus("seqC.exitWins", ST_HALTED, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);

        $display("[TB] cycle counter saturation");
        cmd(OP_RUN, 8'h00, 8'h00, 1'b0);
        checkStatus("seqD.run", ST_RUN, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
        expCyc = 4'd2;
        for (int i = 0; i < 20; i++) begin
            idle(8'h01, 1'b0);
            if (expCyc != 4'hF) expCyc = expCyc + 4'd1;
            checkOutput($sformatf("seqD.cycles%0d", i), 32'(cycles), 32'(expCyc));
        end
        cmd(OP_HALT, 8'h00, 8'h01, 1'b0);
        checkStatus("seqD.halt", ST_HALTED, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15);

        $display("[TB] asynchronous reset during run and during a load");
        cmd(OP_RUN, 8'h00, 8'h01, 1'b0);
        checkOutput("seqE.running", 32'(cpu_en), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkStatus("seqE.rstRun", ST_IDLE, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("seqE.rstRun.imemWe", 32'(imem_we), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        modelPtr = 8'h00;
        #1;
        checkOutput("seqE.release.cpuRst", 32'(cpu_rst), 32'd0);
        cmd(OP_LOAD_ADDR, 8'h10, 8'h00, 1'b0);
        cmd(OP_LOAD_BYTE, 8'hAA, 8'h00, 1'b0);
        checkOutput("seqE.loadAA.imemWe", 32'(imem_we), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD_BYTE;
        cmd_data  = 8'hBB;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checkOutput("seqE.loadBB.imemWe", 32'(imem_we), 32'd1);
        checkOutput("seqE.loadBB.imemAddr", 32'(imem_addr), 32'h11);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("seqE.abort.imemWe", 32'(imem_we), 32'd0);
        checkStatus("seqE.abort", ST_IDLE, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        @(negedge clk);
        reset    = 1'b0;
        modelPtr = 8'h00;
        idle(8'h00, 1'b0);
        checkOutput("seqE.noStrayWe1", 32'(imem_we), 32'd0);
        idle(8'h00, 1'b0);
        checkOutput("seqE.noStrayWe2", 32'(imem_we), 32'd0);
        cmd(OP_LOAD_BYTE, 8'hCC, 8'h00, 1'b0);
        checkOutput("seqE.loadCC.imemWe", 32'(imem_we), 32'd1);
        idle(8'h00, 1'b0);
        checkOutput("seqE.afterCC.imemWe", 32'(imem_we), 32'd0);

        checkOutput("scoreboardEmpty", 32'(wrQueue.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
